// File: rtl/mem_unloader_if.sv
// SRAM read port and coefficient output stream shared by mem_unloader and its neighbours.
// The master side is the unloader. Its parameters must match the unloader's parameters.
interface mem_unloader_if #(
    parameter int D_WIDTH = 32,
    parameter int BN      = 16,
    parameter int MA      = 512
);
    localparam int BANK_W = $clog2(BN);
    localparam int ADDR_W = $clog2(MA);
    localparam int IDX_W  = BANK_W + ADDR_W;

    logic               rd_en;
    logic [BANK_W-1:0]  rd_bank;
    logic [ADDR_W-1:0]  rd_addr;
    logic [D_WIDTH-1:0] rd_data;
    logic               out_valid;
    logic               out_ready;
    logic [D_WIDTH-1:0] out_data;
    logic [IDX_W-1:0]   out_index;
    logic               out_last;

    modport master (
        output rd_en, rd_bank, rd_addr,
        input  rd_data,
        output out_valid, out_data, out_index, out_last,
        input  out_ready
    );

    modport slave (
        input  rd_en, rd_bank, rd_addr,
        output rd_data,
        input  out_valid, out_data, out_index, out_last,
        output out_ready
    );
endinterface

// File: rtl/mem_unloader.sv
// Drains the BN x MA interleaved SRAM banks in natural coefficient order onto a valid/ready stream.
// state | meaning
// IDLE  | waiting for start
// READ  | issuing one bank read per cycle while the output FIFO has credit
// DRAIN | all reads issued, waiting for the last beat to be accepted
// FIN   | one-cycle done pulse
module mem_unloader #(
    parameter int D_WIDTH = 32,
    parameter int BN      = 16,
    parameter int MA      = 512,
    parameter int BANK_W  = $clog2(BN),
    parameter int ADDR_W  = $clog2(MA),
    parameter int IDX_W   = BANK_W + ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    mem_unloader_if.master   bus
);
    localparam logic [IDX_W:0] LAST_IDX = (IDX_W+1)'(BN*MA - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    state_t             state;
    logic [IDX_W:0]     idx;
    logic               inflight;
    logic [IDX_W-1:0]   infl_idx;
    logic               sk_valid;
    logic [D_WIDTH-1:0] sk_data;
    logic [IDX_W-1:0]   sk_index;
    logic               sk_last;
    logic               pop;
    logic               in_last;
    logic [2:0]         occ;

    assign pop     = bus.out_valid & bus.out_ready;
    assign in_last = &infl_idx;
    // Entries held or arriving after this edge; pop implies out_valid so no underflow.
    assign occ     = {2'b0, bus.out_valid} + {2'b0, sk_valid} + {2'b0, inflight} - {2'b0, pop};

    assign bus.rd_en   = (state == READ) && (occ < 3'd2);
    assign bus.rd_bank = idx[BANK_W-1:0];
    assign bus.rd_addr = idx[IDX_W-1:BANK_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            idx      <= '0;
            inflight <= 1'b0;
            infl_idx <= '0;
        end else begin
            done     <= 1'b0;
            inflight <= bus.rd_en;
            infl_idx <= idx[IDX_W-1:0];
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= READ;
                        busy  <= 1'b1;
                        idx   <= '0;
                    end
                end
                READ: begin
                    if (bus.rd_en) begin
                        idx <= idx + 1'b1;
                        if (idx == LAST_IDX) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && bus.out_last) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Two-entry FIFO: the output register is the head, sk_* is the second slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_index <= '0;
            bus.out_last  <= 1'b0;
            sk_valid      <= 1'b0;
            sk_data       <= '0;
            sk_index      <= '0;
            sk_last       <= 1'b0;
        end else if (state == IDLE && start) begin
            bus.out_valid <= 1'b0;
            sk_valid      <= 1'b0;
        end else if (!bus.out_valid || pop) begin
            if (sk_valid) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= sk_data;
                bus.out_index <= sk_index;
                bus.out_last  <= sk_last;
                sk_valid      <= inflight;
                sk_data       <= bus.rd_data;
                sk_index      <= infl_idx;
                sk_last       <= in_last;
            end else if (inflight) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= bus.rd_data;
                bus.out_index <= infl_idx;
                bus.out_last  <= in_last;
            end else begin
                bus.out_valid <= 1'b0;
            end
        end else if (inflight) begin
            sk_valid <= 1'b1;
            sk_data  <= bus.rd_data;
            sk_index <= infl_idx;
            sk_last  <= in_last;
        end
    end
endmodule

// File: tb/tb_mem_unloader.sv
// Self-checking bench for mem_unloader: banked memory model, in-order stream scoreboard,
// outstanding-read bound, stall stability and cycle-exact timing of the first run.
module tb_mem_unloader;
    localparam int DW = 32;
    localparam int BN = 16;
    localparam int MA = 512;
    localparam int N  = BN * MA;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;

    mem_unloader_if #(.D_WIDTH(DW), .BN(BN), .MA(MA)) bus ();

    mem_unloader #(.D_WIDTH(DW), .BN(BN), .MA(MA)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem_b [BN][MA];

    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem_b[bus.rd_bank][bus.rd_addr];
    end

    int total = 0;
    int bad   = 0;
    int cyc;
    int issued;
    int exp_acc;
    int done_cnt;
    bit exp_busy;
    bit exp_done;
    bit prev_hold;
    logic [DW-1:0] prev_data;
    logic [12:0]   prev_index;
    logic          prev_last;

    function automatic logic [DW-1:0] coef(input int i);
        return mem_b[i % BN][i / BN];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy",      64'(busy), 0);
        chk("rst_done",      64'(done), 0);
        chk("rst_rd_en",     64'(bus.rd_en), 0);
        chk("rst_rd_bank",   64'(bus.rd_bank), 0);
        chk("rst_rd_addr",   64'(bus.rd_addr), 0);
        chk("rst_out_valid", 64'(bus.out_valid), 0);
        chk("rst_out_data",  64'(bus.out_data), 0);
        chk("rst_out_index", 64'(bus.out_index), 0);
        chk("rst_out_last",  64'(bus.out_last), 0);
    endtask

    task automatic model_clear();
        exp_busy  = 1'b0;
        exp_done  = 1'b0;
        prev_hold = 1'b0;
        issued    = 0;
        exp_acc   = 0;
    endtask

    // Compare against the stream model once per cycle, sampled at the falling edge.
    task automatic monitor(input bit st);
        bit pop;
        bit nb;
        bit nd;
        pop = bus.out_valid && bus.out_ready;
        nb  = exp_busy;
        nd  = 1'b0;
        chk("busy", 64'(busy), 64'(exp_busy));
        chk("done", 64'(done), 64'(exp_done));
        if (done) done_cnt++;
        if (!exp_busy) begin
            chk("idle_rd_en", 64'(bus.rd_en), 0);
            chk("idle_valid", 64'(bus.out_valid), 0);
        end
        if (st && !exp_busy && !exp_done) begin
            issued  = 0;
            exp_acc = 0;
            nb      = 1'b1;
        end
        if (bus.rd_en) begin
            chk("rd_index", 64'({bus.rd_addr, bus.rd_bank}), 64'(issued));
            chk("credit", 64'((issued - exp_acc - int'(pop)) < 2), 1);
            issued++;
        end
        if (prev_hold) begin
            chk("hold_valid", 64'(bus.out_valid), 1);
            chk("hold_data",  64'(bus.out_data), 64'(prev_data));
            chk("hold_index", 64'(bus.out_index), 64'(prev_index));
            chk("hold_last",  64'(bus.out_last), 64'(prev_last));
        end
        if (pop) begin
            chk("out_index", 64'(bus.out_index), 64'(exp_acc));
            chk("out_data",  64'(bus.out_data), 64'(coef(exp_acc)));
            chk("out_last",  64'(bus.out_last), 64'(exp_acc == N - 1));
            if (exp_acc == N - 1) begin
                nb = 1'b0;
                nd = 1'b1;
            end
            exp_acc++;
        end
        prev_hold  = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        prev_index = bus.out_index;
        prev_last  = bus.out_last;
        exp_busy   = nb;
        exp_done   = nd;
    endtask

    task automatic tick(input bit rdy, input bit st);
        @(posedge clk);
        #1;
        bus.out_ready = rdy;
        start         = st;
        cyc++;
        @(negedge clk);
        monitor(st);
    endtask

    task automatic mid_reset();
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        model_clear();
    endtask

    // mode 0 full rate, 1 random backpressure, 2 full stall, 3 start while busy, 4 reset mid-unload
    task automatic run(input int mode);
        int  guard;
        bit  rdy;
        bit  st;
        bit  pulsed;
        guard    = 0;
        pulsed   = 1'b0;
        done_cnt = 0;
        cyc      = -1;
        tick(1'b1, 1'b1);
        while (done_cnt == 0 && guard < 40000) begin
            guard++;
            st  = 1'b0;
            rdy = 1'b1;
            if (mode == 1) rdy = 1'($urandom_range(0, 1));
            if (mode == 2 && cyc + 1 >= 3 && cyc + 1 < 23) rdy = 1'b0;
            if (mode == 3 && exp_acc == 500 && !pulsed) begin
                st     = 1'b1;
                pulsed = 1'b1;
            end
            tick(rdy, st);
            if (mode == 0) begin
                if (cyc == 1) chk("c1_rd_en", 64'(busy && bus.rd_en), 1);
                if (cyc == 2) chk("c2_valid", 64'(bus.out_valid), 0);
                if (cyc == 3) chk("c3_valid", 64'(bus.out_valid), 1);
                if (bus.out_valid && bus.out_last) chk("last_cycle", 64'(cyc), 64'(N + 2));
                if (done) chk("done_cycle", 64'(cyc), 64'(N + 3));
            end
            if (mode == 2 && cyc >= 3 && cyc < 23) begin
                chk("stall_rd_en", 64'(bus.rd_en), 0);
                chk("stall_index", 64'(bus.out_index), 0);
                chk("stall_data",  64'(bus.out_data), 64'(coef(0)));
                if (cyc == 22) chk("stall_issued", 64'(issued), 2);
            end
            if (mode == 4 && exp_acc == 101) begin
                mid_reset();
                return;
            end
        end
        if (done_cnt == 0) chk("timeout", 64'(guard), 0);
        repeat (4) tick(1'b1, 1'b0);
        chk("accepted", 64'(exp_acc), 64'(N));
        chk("done_count", 64'(done_cnt), 1);
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        bus.out_ready = 1'b0;
        cyc           = 0;
        done_cnt      = 0;
        model_clear();
        for (int b = 0; b < BN; b++)
            for (int k = 0; k < MA; k++)
                mem_b[b][k] = 32'(k * 16 + b);
        #2;
        check_reset_outputs();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        run(0);
        for (int b = 0; b < BN; b++)
            for (int k = 0; k < MA; k++)
                mem_b[b][k] = $urandom;
        run(1);
        run(2);
        run(3);
        run(4);
        run(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
